// File: rtl/ghost_position_reg_pkg.sv
// ghost_position_reg_pkg: arena geometry, tile constants and ghost pacer state encodings
package ghost_position_reg_pkg;
   localparam int WIDTH         = 640;
   localparam int HEIGHT        = 480;
   localparam int TILE_SIZE     = 20;
   localparam int TILE_COL_NUM  = WIDTH / TILE_SIZE;
   localparam int TILE_ROW_NUM  = HEIGHT / TILE_SIZE;
   localparam int TILES         = TILE_ROW_NUM * TILE_COL_NUM;
   localparam int X_W           = $clog2(WIDTH);
   localparam int Y_W           = $clog2(HEIGHT);
   localparam int IDX_W         = $clog2(TILES);
   typedef enum logic {
      GPR_RUN    = 1'b0,
      GPR_PARKED = 1'b1
   } gpr_state_e;
endpackage

// File: rtl/ghost_position_reg_tile_wall_lookup.sv
// tile_wall_lookup: wall bit and tile alignment of a pixel position (x,y,tilemap -> wall,aligned)
module tile_wall_lookup
   import ghost_position_reg_pkg::*;
(
   input  logic [X_W-1:0]   x,
   input  logic [Y_W-1:0]   y,
   input  logic [TILES-1:0] tilemap,
   output logic             wall,
   output logic             aligned
);
   logic [X_W-1:0]   w_col;
   logic [Y_W-1:0]   w_row;
   logic [IDX_W-1:0] w_idx;
   assign w_col   = x / X_W'(TILE_SIZE);
   assign w_row   = y / Y_W'(TILE_SIZE);
   assign w_idx   = IDX_W'(w_row) * IDX_W'(TILE_COL_NUM) + IDX_W'(w_col);
   assign wall    = (w_idx < IDX_W'(TILES)) ? tilemap[w_idx] : 1'b0;
   assign aligned = (x % X_W'(TILE_SIZE) == '0) && (y % Y_W'(TILE_SIZE) == '0);
endmodule

// File: rtl/ghost_position_reg.sv
// ghost_position_reg: ghost position register, move pacer and capture/respawn; wall test enabled by GHOST_WALL_CHECK_EN
module ghost_position_reg
   import ghost_position_reg_pkg::*;
#(
   parameter int HOME_X        = 20,
   parameter int HOME_Y        = 160,
   parameter int TICK_DIV      = 12_500_000,
   parameter int RESPAWN_TICKS = 8,
   parameter int BOUND_X1      = 620,
   parameter int BOUND_Y1      = 460
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [X_W-1:0]   next_x,
   input  logic [Y_W-1:0]   next_y,
   input  logic [X_W-1:0]   pac_x,
   input  logic [Y_W-1:0]   pac_y,
   input  logic [TILES-1:0] tilemap_walls,
   output logic [X_W-1:0]   x,
   output logic [Y_W-1:0]   y,
   output logic             move_strobe,
   output logic             blocked,
   output logic             caught,
   output logic             active
);
   localparam int CNT_W  = $clog2(TICK_DIV);
   localparam int PARK_W = $clog2(RESPAWN_TICKS + 1);
`ifdef GHOST_WALL_CHECK_EN
   localparam bit WALL_EN = 1'b1;
`else
   localparam bit WALL_EN = 1'b0;
`endif
   gpr_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [PARK_W-1:0] r_park;
   logic [X_W-1:0]   r_x;
   logic [Y_W-1:0]   r_y;
   logic             r_blocked;
   logic             r_strobe;
   logic             r_caught;
   logic             r_active;
   logic             w_wall;
   logic             w_aligned;
   logic             w_tick;
   logic             w_contact;
   logic             w_legal;
   tile_wall_lookup u_lookup (
      .x       (next_x),
      .y       (next_y),
      .tilemap (tilemap_walls),
      .wall    (w_wall),
      .aligned (w_aligned)
   );
   assign w_tick    = run && (r_cnt == CNT_W'(TICK_DIV - 1));
   assign w_contact = run && (r_state == GPR_RUN) && (r_x == pac_x) && (r_y == pac_y);
   assign w_legal   = (next_x <= X_W'(BOUND_X1)) && (next_y <= Y_W'(BOUND_Y1)) && w_aligned && !(WALL_EN && w_wall);
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= GPR_RUN;
         r_cnt     <= '0;
         r_park    <= '0;
         r_x       <= X_W'(HOME_X);
         r_y       <= Y_W'(HOME_Y);
         r_blocked <= 1'b0;
         r_strobe  <= 1'b0;
         r_caught  <= 1'b0;
         r_active  <= 1'b1;
      end else begin
         r_strobe <= 1'b0;
         r_caught <= 1'b0;
         if (run)
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
         if (w_contact) begin
            r_caught  <= 1'b1;
            r_x       <= X_W'(HOME_X);
            r_y       <= Y_W'(HOME_Y);
            r_blocked <= 1'b0;
            r_park    <= PARK_W'(RESPAWN_TICKS);
            r_state   <= GPR_PARKED;
            r_active  <= 1'b0;
         end else if (w_tick) begin
            r_strobe <= 1'b1;
            if (r_state == GPR_RUN) begin
               r_x       <= w_legal ? next_x : r_x;
               r_y       <= w_legal ? next_y : r_y;
               r_blocked <= !w_legal;
            end else begin
               r_park <= r_park - PARK_W'(1);
               if (r_park == PARK_W'(1)) begin
                  r_state  <= GPR_RUN;
                  r_active <= 1'b1;
               end
            end
         end
      end
   end
   assign x           = r_x;
   assign y           = r_y;
   assign move_strobe = r_strobe;
   assign blocked     = r_blocked;
   assign caught      = r_caught;
   assign active      = r_active;
endmodule

// File: tb/tb_ghost_position_reg.sv
// tb_ghost_position_reg: directed table, corner sequences and randomized model check of ghost_position_reg
module tb_ghost_position_reg;
   localparam int TD = 4;
   localparam int RT = 8;
`ifdef GHOST_WALL_CHECK_EN
   localparam int WX = 20;
   localparam int WB = 1;
`else
   localparam int WX = 40;
   localparam int WB = 0;
`endif
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         run = 1'b1;
   logic [9:0]   next_x = 10'd20;
   logic [8:0]   next_y = 9'd160;
   logic [9:0]   pac_x = 10'd600;
   logic [8:0]   pac_y = 9'd440;
   logic [767:0] walls = '0;
   logic [9:0]   x;
   logic [8:0]   y;
   logic         move_strobe, blocked, caught, active;
   int n_tests = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;
   int m_x, m_y, m_blk, m_str, m_cau, m_parked, m_park, m_phase;
   typedef struct {
      int widx;
      int nx;
      int ny;
      int ex;
      int ey;
      int eb;
   } vec_t;
   vec_t tbl[9];
   ghost_position_reg #(.TICK_DIV(TD), .RESPAWN_TICKS(RT)) dut (
      .clk(clk), .reset(reset), .run(run), .next_x(next_x), .next_y(next_y),
      .pac_x(pac_x), .pac_y(pac_y), .tilemap_walls(walls), .x(x), .y(y),
      .move_strobe(move_strobe), .blocked(blocked), .caught(caught), .active(active)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask
   function automatic bit m_legal(input int nx, input int ny);
      if (nx > 620 || ny > 460 || nx % 20 != 0 || ny % 20 != 0)
         return 1'b0;
`ifdef GHOST_WALL_CHECK_EN
      if (walls[(ny / 20) * 32 + nx / 20])
         return 1'b0;
`endif
      return 1'b1;
   endfunction
   task automatic model_update();
      bit t;
      if (reset) begin
         m_x = 20; m_y = 160; m_blk = 0; m_str = 0; m_cau = 0;
         m_parked = 0; m_park = 0; m_phase = 0;
      end else begin
         t = run && (m_phase == TD - 1);
         m_str = 0;
         m_cau = 0;
         if (run)
            m_phase = (m_phase + 1) % TD;
         if (run && m_parked == 0 && m_x == int'(pac_x) && m_y == int'(pac_y)) begin
            m_cau = 1; m_x = 20; m_y = 160; m_blk = 0; m_parked = 1; m_park = RT;
         end else if (t) begin
            m_str = 1;
            if (m_parked == 0) begin
               if (m_legal(int'(next_x), int'(next_y))) begin
                  m_x = int'(next_x); m_y = int'(next_y); m_blk = 0;
               end else
                  m_blk = 1;
            end else begin
               m_park--;
               if (m_park == 0)
                  m_parked = 0;
            end
         end
      end
   endtask
   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      if (chk_en) begin
         chk("rnd_x", int'(x), m_x);
         chk("rnd_y", int'(y), m_y);
         chk("rnd_strobe", int'(move_strobe), m_str);
         chk("rnd_blocked", int'(blocked), m_blk);
         chk("rnd_caught", int'(caught), m_cau);
         chk("rnd_active", int'(active), 1 - m_parked);
      end
   endtask
   task automatic wait_strobe(input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!move_strobe && n < budget);
      chk("strobe_seen", int'(move_strobe), 1);
   endtask
   initial begin
      int n;
      int cnt_s;
      tbl[0] = '{8 * 32 + 2, 40, 160, WX, 160, WB};
      tbl[1] = '{-1, 40, 160, 40, 160, 0};
      tbl[2] = '{-1, 640, 160, 40, 160, 1};
      tbl[3] = '{-1, 45, 160, 40, 160, 1};
      tbl[4] = '{-1, 40, 180, 40, 180, 0};
      tbl[5] = '{-1, 620, 460, 620, 460, 0};
      tbl[6] = '{-1, 620, 480, 620, 460, 1};
      tbl[7] = '{-1, 0, 0, 0, 0, 0};
      tbl[8] = '{-1, 20, 160, 20, 160, 0};
      @(negedge clk);
      step();
      chk("rst_x", int'(x), 20);
      chk("rst_y", int'(y), 160);
      chk("rst_active", int'(active), 1);
      chk("rst_strobe", int'(move_strobe), 0);
      chk("rst_caught", int'(caught), 0);
      chk("rst_blocked", int'(blocked), 0);
      reset = 1'b0;
      wait_strobe(3 * TD, n);
      chk("first_strobe_latency", n, TD);
      for (int i = 0; i < 9; i++) begin
         walls = '0;
         if (tbl[i].widx >= 0)
            walls[tbl[i].widx] = 1'b1;
         next_x = 10'(tbl[i].nx);
         next_y = 9'(tbl[i].ny);
         wait_strobe(2 * TD, n);
         chk($sformatf("vec%0d_x", i), int'(x), tbl[i].ex);
         chk($sformatf("vec%0d_y", i), int'(y), tbl[i].ey);
         chk($sformatf("vec%0d_blocked", i), int'(blocked), tbl[i].eb);
      end
      walls = '0;
      next_x = 10'd40;
      next_y = 9'd160;
      wait_strobe(2 * TD, n);
      chk("pre_capture_x", int'(x), 40);
      repeat (TD - 1) step();
      pac_x = 10'd40;
      pac_y = 9'd160;
      next_x = 10'd60;
      step();
      chk("capture_caught", int'(caught), 1);
      chk("capture_no_strobe", int'(move_strobe), 0);
      chk("capture_x", int'(x), 20);
      chk("capture_y", int'(y), 160);
      chk("capture_active", int'(active), 0);
      pac_x = 10'd600;
      pac_y = 9'd440;
      step();
      chk("caught_one_cycle", int'(caught), 0);
      for (int k = 1; k <= RT; k++) begin
         wait_strobe(2 * TD, n);
         if (k == RT - 1)
            chk("park_active_before_last", int'(active), 0);
         if (k == RT)
            chk("park_active_after_last", int'(active), 1);
      end
      chk("park_home_x", int'(x), 20);
      step();
      run = 1'b0;
      cnt_s = 0;
      repeat (10) begin
         step();
         cnt_s += int'(move_strobe);
      end
      chk("freeze_strobes", cnt_s, 0);
      run = 1'b1;
      wait_strobe(2 * TD, n);
      chk("freeze_resume_latency", n, TD - 1);
      chk("freeze_commit_x", int'(x), 60);
      reset = 1'b1;
      pac_x = 10'd20;
      pac_y = 9'd160;
      step();
      reset = 1'b0;
      step();
      chk("home_contact_caught", int'(caught), 1);
      chk("home_contact_active", int'(active), 0);
      pac_x = 10'd600;
      pac_y = 9'd440;
      repeat (2) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("park_rst_x", int'(x), 20);
      chk("park_rst_y", int'(y), 160);
      chk("park_rst_active", int'(active), 1);
      chk("park_rst_strobe", int'(move_strobe), 0);
      wait_strobe(3 * TD, n);
      chk("park_rst_latency", n, TD);
      for (int i = 0; i < 768; i++)
         walls[i] = ($urandom_range(0, 3) == 0);
      reset = 1'b1;
      step();
      chk_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 299) == 0);
         run = ($urandom_range(0, 99) < 90);
         next_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'(20 * $urandom_range(0, 32));
         next_y = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'(20 * $urandom_range(0, 24));
         if ($urandom_range(0, 29) == 0) begin
            pac_x = 10'(m_x);
            pac_y = 9'(m_y);
         end else begin
            pac_x = 10'(20 * $urandom_range(0, 31));
            pac_y = 9'(20 * $urandom_range(0, 23));
         end
         walls[$urandom_range(0, 767)] = ~walls[$urandom_range(0, 767)];
         step();
         chk("rnd_exclusive", int'(caught && move_strobe), 0);
      end
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ghost_position_reg.md
# ghost_position_reg

Position register and movement pacer for one ghost, directly downstream of the ghost control stage. It holds the ghost's committed pixel position and feeds it back as the control stage's `x`/`y`. It pulls in the proposed `next_x`/`next_y` once per move tick, vets the proposal against the arena boundary and wall tilemap, and commits it. It also detects Pac-Man contact, then parks the ghost at home for a respawn delay.

## Interface
- `HOME_X`, 20: respawn/reset x in pixels, tile-aligned.
- `HOME_Y`, 160: respawn/reset y in pixels, tile-aligned.
- `TICK_DIV`, 12_500_000: clock cycles per move tick, ≥ 2.
- `RESPAWN_TICKS`, 8: move ticks spent parked after capture, ≥ 1.
- `BOUND_X1`, 620; `BOUND_Y1`, 460: inclusive upper limits. Lower limits are 0.
- `clk`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high.
- `run`  in  1  game running. Low freezes the tick counter and the state.
- `next_x`  in  $clog2(`WIDTH)  proposed x from the ghost control stage.
- `next_y`  in  $clog2(`HEIGHT)  proposed y from the ghost control stage.
- `pac_x`  in  $clog2(`WIDTH)  Pac-Man committed x.
- `pac_y`  in  $clog2(`HEIGHT)  Pac-Man committed y.
- `tilemap_walls`  in  `tile_row_num*`tile_col_num  bit (row*`tile_col_num + col) is 1 for a wall.
- `x`  out  $clog2(`WIDTH)  committed ghost x, registered.
- `y`  out  $clog2(`HEIGHT)  committed ghost y, registered.
- `move_strobe`  out  1  one-cycle pulse on every tick at which `x`/`y` are re-evaluated.
- `blocked`  out  1  the last tick's proposal was rejected.
- `caught`  out  1  one-cycle pulse when Pac-Man contact is detected.
- `active`  out  1  high in RUN, low while parked.

## Operation
- States are RUN and PARKED.
- Tick counter `cnt`:
  - While `run`=1, it counts 0..TICK_DIV-1 and wraps to 0.
  - `tick` = (`cnt`==TICK_DIV-1 && `run`).
  - While `run`=0, it holds its value.
- RUN, on `tick`:
  - Tile index = (`next_y`/20)*`tile_col_num + `next_x`/20. Use a constant-divisor divide, not a general divider.
  - The proposal is legal when all of these hold:
    - `next_x` ≤ BOUND_X1 and `next_y` ≤ BOUND_Y1;
    - both are multiples of 20;
    - the wall bit is 0.
  - Legal: `x`,`y` ← `next_x`,`next_y` and `blocked` ← 0. Illegal: hold `x`,`y` and set `blocked` ← 1.
  - `move_strobe` pulses in either case.
- Contact in RUN: if (`x`,`y`) == (`pac_x`,`pac_y`) in any cycle with `run`=1:
  - pulse `caught`;
  - load `x`,`y` ← HOME;
  - clear `blocked`;
  - load the park counter with RESPAWN_TICKS;
  - go to PARKED.
  - Contact takes priority over a same-cycle `tick`: no commit, no `move_strobe`.
- PARKED:
  - Each `tick` decrements the park counter and pulses `move_strobe`. Position is held at HOME.
  - When the counter reaches 0 on a tick, go to RUN. The first proposal is evaluated at the following tick.
  - Contact is ignored while PARKED.
- Reset values: `x`=HOME_X, `y`=HOME_Y, state RUN, `cnt`=0, `blocked`=0, `move_strobe`=0, `caught`=0, `active`=1, park counter 0.
- A reset mid-operation, including in PARKED, aborts everything to those values on the next edge.

## Timing
- Every output is registered. Commit latency is 1 clock from the cycle in which `tick` is true.
- The control stage sees the new `x`/`y` one cycle after `move_strobe`. Its registered `next_*` settles 1 cycle later, well before the next tick.
- `caught` and `move_strobe` are exactly one cycle wide and are never high together.
- Contact is sampled on the registered `x`/`y`, so it is detected no later than 1 cycle after a commit.

## Configuration
- `GHOST_WALL_CHECK_EN`:
  - Defined: legality uses the boundary, alignment and wall-bit tests above.
  - Undefined: `tilemap_walls` is ignored and only the boundary/alignment tests apply. The control stage's hard-coded path is trusted.

## Structure
- The shared `define.v` already holds `WIDTH, `HEIGHT, `tile_row_num, `tile_col_num and the `dir_*` codes. Add to it:
  - `TILE_SIZE` (20);
  - the state encodings `GPR_RUN` and `GPR_PARKED`.
- One sub-module, `tile_wall_lookup`: combinational. It takes x, y and the tilemap and returns `wall` and `aligned`. Pac-Man's mover reuses it.

## Test plan
- Reset high 1 cycle, then low with `run`=1 -> `x`=20, `y`=160, `active`=1. First `move_strobe` arrives exactly TICK_DIV cycles later (use TICK_DIV=4 in sim).
- `next`=(40,160), no walls, Pac-Man at (600,440) -> after the tick, `x`=40, `blocked`=0.
- Set the wall bit for tile (2,8), `next`=(40,160) -> `x` stays 20 and `blocked`=1. With `GHOST_WALL_CHECK_EN` undefined -> `x`=40.
- `next`=(640,160) or (45,160) -> rejected, `blocked`=1.
- Pac-Man moves onto (40,160) on the same cycle as a tick -> `caught` pulses, `x`,`y`=(20,160), `active`=0, no `move_strobe` that cycle. After 8 ticks `active`=1.
- Drop `run` for 10 cycles mid-count -> `cnt` frozen, no strobes. Assert `reset` while PARKED -> RUN at HOME with `cnt`=0.
